// File: rtl/boss_pkg.sv
// Shared constants, types and the motion-command priority encoder for the boss sprite datapath.
package boss_pkg;

  localparam int unsigned POS_W    = 10;
  localparam int unsigned HP_W     = 5;
  localparam int unsigned IF_W     = 4;

  localparam int unsigned X_CENTER = 320;
  localparam int unsigned X_MIN    = 60;
  localparam int unsigned X_MAX    = 580;
  localparam int unsigned Y_TOP    = 40;
  localparam int unsigned Y_BOTTOM = 360;
  localparam int unsigned X_STEP   = 2;
  localparam int unsigned Y_DOWN   = 4;
  localparam int unsigned Y_UP     = 2;
  localparam int unsigned MAX_HP   = 16;
  localparam int unsigned IFRAMES  = 8;

  typedef enum logic [1:0] {CMD_HOLD, CMD_BNF, CMD_DOWN, CMD_UP} motion_cmd_t;
  typedef enum logic {DIR_POS, DIR_NEG} dir_t;

  // The control FSM drives one-hot commands; the fixed priority keeps the datapath
  // well defined if more than one is ever asserted.
  function automatic motion_cmd_t encode_cmd(input logic down, input logic up,
                                             input logic bnf, input logic hold);
    if (down)      return CMD_DOWN;
    else if (up)   return CMD_UP;
    else if (bnf)  return CMD_BNF;
    else if (hold) return CMD_HOLD;
    return CMD_HOLD;
  endfunction

endpackage

// File: rtl/boss_motion_if.sv
// Command/status bundle between the boss control FSM side and the boss motion datapath.
interface boss_motion_if;
  import boss_pkg::*;

  logic [2:0]       difficulty;
  logic             Boss_exists;
  logic             boss_hold;
  logic             boss_back_and_forth;
  logic             boss_flydown;
  logic             boss_rise;
  logic             bullet_hit;
  logic [POS_W-1:0] BossX;
  logic [POS_W-1:0] BossY;
  logic             hit_bottom;
  logic             hit_top;
  logic [HP_W-1:0]  boss_hp;
  logic             boss_flash;
  logic             beat_Boss;

  modport master (
    output difficulty, Boss_exists, boss_hold, boss_back_and_forth, boss_flydown,
           boss_rise, bullet_hit,
    input  BossX, BossY, hit_bottom, hit_top, boss_hp, boss_flash, beat_Boss
  );

  modport slave (
    input  difficulty, Boss_exists, boss_hold, boss_back_and_forth, boss_flydown,
           boss_rise, bullet_hit,
    output BossX, BossY, hit_bottom, hit_top, boss_hp, boss_flash, beat_Boss
  );
endinterface

// File: rtl/boss_health.sv
// Boss health: hit counter with invulnerability frames and the sticky defeat flag.
module boss_health
  import boss_pkg::*;
(
  input  logic            frame_clk,
  input  logic            Reset_n,
  input  logic            boss_exists,
  input  logic            bullet_hit,
  output logic [HP_W-1:0] boss_hp,
  output logic            boss_flash,
  output logic            beat_boss
);

  logic [IF_W-1:0] iframe;
  logic            hit_ok;

  // Hits landing while invulnerable or already dead are dropped, never queued.
  assign hit_ok     = bullet_hit && boss_exists && (iframe == '0) && (boss_hp != '0);
  assign boss_flash = (iframe != '0);

  // Health, invulnerability countdown and defeat latch.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      boss_hp   <= HP_W'(MAX_HP);
      iframe    <= '0;
      beat_boss <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      beat_boss <= beat_boss || (boss_hp == '0);
      if (!boss_exists) begin
        iframe <= '0;
        // A defeated boss keeps hp at 0 until a full reset.
        if (!beat_boss && boss_hp != '0) boss_hp <= HP_W'(MAX_HP);
      end else if (hit_ok) begin
        boss_hp <= boss_hp - HP_W'(1);
        iframe  <= IF_W'(IFRAMES);
      end else if (iframe != '0) begin
        iframe <= iframe - IF_W'(1);
      end
    end
  end

endmodule

// File: rtl/boss_motion.sv
// Boss sprite motion datapath: applies FSM motion commands to the sprite position,
// reports floor/ceiling contact and wraps the health tracker.
module boss_motion
  import boss_pkg::*;
(
  input  logic         frame_clk,
  input  logic         Reset_n,
  boss_motion_if.slave bus
);

  logic [POS_W-1:0] boss_x, boss_y, x_nxt, y_nxt;
  dir_t             dir, dir_nxt;
  motion_cmd_t      cmd;
  logic [POS_W:0]   step;

  assign cmd  = encode_cmd(bus.boss_flydown, bus.boss_rise, bus.boss_back_and_forth,
                           bus.boss_hold);
  assign step = (POS_W+1)'(X_STEP) + (POS_W+1)'(bus.difficulty);

  // Next position/direction; all arithmetic one bit wider than the position to avoid wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    x_nxt   = boss_x;
    y_nxt   = boss_y;
    dir_nxt = dir;
    if (!bus.Boss_exists) begin
      x_nxt   = POS_W'(X_CENTER);
      y_nxt   = POS_W'(Y_TOP);
      dir_nxt = DIR_POS;
    end else begin
      unique case (cmd)
        CMD_DOWN: begin
          if (({1'b0, boss_y} + (POS_W+1)'(Y_DOWN)) >= (POS_W+1)'(Y_BOTTOM))
            y_nxt = POS_W'(Y_BOTTOM);
          else
            y_nxt = POS_W'({1'b0, boss_y} + (POS_W+1)'(Y_DOWN));
        end
        CMD_UP: begin
          if ({1'b0, boss_y} < (POS_W+1)'(Y_TOP + Y_UP))
            y_nxt = POS_W'(Y_TOP);
          else
            y_nxt = POS_W'({1'b0, boss_y} - (POS_W+1)'(Y_UP));
        end
        CMD_BNF: begin
          if (dir == DIR_POS) begin
            if (({1'b0, boss_x} + step) >= (POS_W+1)'(X_MAX)) begin
              x_nxt   = POS_W'(X_MAX);
              dir_nxt = DIR_NEG;
            end else begin
              x_nxt = POS_W'({1'b0, boss_x} + step);
            end
          end else begin
            if ({1'b0, boss_x} < ((POS_W+1)'(X_MIN) + step)) begin
              x_nxt   = POS_W'(X_MIN);
              dir_nxt = DIR_POS;
            end else begin
              x_nxt = POS_W'({1'b0, boss_x} - step);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Position and direction registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      boss_x <= POS_W'(X_CENTER);
      boss_y <= POS_W'(Y_TOP);
      dir    <= DIR_POS;
    end else begin
      boss_x <= x_nxt;
      boss_y <= y_nxt;
      dir    <= dir_nxt;
    end
  end

  assign bus.BossX      = boss_x;
  assign bus.BossY      = boss_y;
  assign bus.hit_bottom = bus.Boss_exists && (boss_y == POS_W'(Y_BOTTOM));
  assign bus.hit_top    = bus.Boss_exists && (boss_y == POS_W'(Y_TOP));

  boss_health u_health (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .boss_exists (bus.Boss_exists),
    .bullet_hit  (bus.bullet_hit),
    .boss_hp     (bus.boss_hp),
    .boss_flash  (bus.boss_flash),
    .beat_boss   (bus.beat_Boss)
  );

endmodule

// File: tb/tb_boss_motion.sv
// Scoreboard bench for boss_motion: a driver applies one frame of inputs, advances a
// behavioural model and queues the expected state; a monitor compares after each edge.
module tb_boss_motion;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b1;
  bit   clk_run   = 1'b0;

  always #5 if (clk_run) frame_clk = ~frame_clk;

  boss_motion_if bus();

  boss_motion dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  typedef struct {
    int x, y, hp, flash, beat, top, bot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of the boss state.
  int mx, my, mdir, mhp, mif;
  bit mbeat;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mx = 320; my = 40; mdir = 1; mhp = 16; mif = 0; mbeat = 0;
  endfunction

  function automatic void model_step(input bit ex, input bit down, input bit up,
                                     input bit bnf, input int diff, input bit hit);
    int  s;
    int  old_hp;
    bit  accept;
    old_hp = mhp;
    accept = hit && ex && (mif == 0) && (mhp != 0);
    if (!ex) begin
      mx = 320; my = 40; mdir = 1;
    end else if (down) begin
      my = (my + 4 > 360) ? 360 : my + 4;
    end else if (up) begin
      my = (my - 2 < 40) ? 40 : my - 2;
    end else if (bnf) begin
      s = 2 + diff;
      if (mdir > 0) begin
        if (mx + s >= 580) begin mx = 580; mdir = -1; end
        else mx = mx + s;
      end else begin
        if (mx < 60 + s) begin mx = 60; mdir = 1; end
        else mx = mx - s;
      end
    end
    if (!ex) begin
      mif = 0;
      if (!mbeat && old_hp != 0) mhp = 16;
    end else if (accept) begin
      mhp = mhp - 1;
      mif = 8;
    end else if (mif > 0) begin
      mif = mif - 1;
    end
    mbeat = mbeat || (old_hp == 0);
  endfunction

  // One frame: drive inputs, predict, and return just after the edge.
  task automatic frame(input bit ex, input bit down, input bit up, input bit bnf,
                       input bit hold, input int diff, input bit hit);
    exp_t e;
    @(negedge frame_clk);
    bus.Boss_exists         = ex;
    bus.boss_flydown        = down;
    bus.boss_rise           = up;
    bus.boss_back_and_forth = bnf;
    bus.boss_hold           = hold;
    bus.difficulty          = 3'(diff);
    bus.bullet_hit          = hit;
    model_step(ex, down, up, bnf, diff, hit);
    e.x = mx; e.y = my; e.hp = mhp; e.flash = int'(mif != 0); e.beat = int'(mbeat);
    e.top = int'(ex && my == 40); e.bot = int'(ex && my == 360);
    exp_q.push_back(e);
    @(posedge frame_clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.Boss_exists = 0; bus.boss_flydown = 0; bus.boss_rise = 0;
    bus.boss_back_and_forth = 0; bus.boss_hold = 0; bus.difficulty = 0; bus.bullet_hit = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, int'(bus.BossX), 320);
    check({tag, "_y"}, int'(bus.BossY), 40);
    check({tag, "_hp"}, int'(bus.boss_hp), 16);
    check({tag, "_beat"}, int'(bus.beat_Boss), 0);
    check({tag, "_flash"}, int'(bus.boss_flash), 0);
    check({tag, "_top"}, int'(bus.hit_top), 0);
    check({tag, "_bot"}, int'(bus.hit_bottom), 0);
  endtask

  // Asynchronous reset between clock edges; values must change without an edge.
  task automatic do_reset(input string tag);
    @(negedge frame_clk);
    #2;
    Reset_n = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    check_reset_vals(tag);
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  // Monitor: compare the DUT with the oldest prediction after each edge.
  always begin
    exp_t e;
    @(posedge frame_clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_x", int'(bus.BossX), e.x);
      check("sb_y", int'(bus.BossY), e.y);
      check("sb_hp", int'(bus.boss_hp), e.hp);
      check("sb_flash", int'(bus.boss_flash), e.flash);
      check("sb_beat", int'(bus.beat_Boss), e.beat);
      check("sb_top", int'(bus.hit_top), e.top);
      check("sb_bot", int'(bus.hit_bottom), e.bot);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    model_reset();

    // Reset with the clock stopped.
    #3 Reset_n = 1'b0;
    #2 check_reset_vals("rst_noclk");
    Reset_n = 1'b1;
    #1 clk_run = 1'b1;

    // Bounce right at base speed from the centre.
    for (int i = 0; i < 130; i++) frame(1, 0, 0, 1, 0, 0, 0);
    check("bnf_reach_max", int'(bus.BossX), 580);
    frame(1, 0, 0, 1, 0, 0, 0);
    check("bnf_turn_back", int'(bus.BossX), 578);

    // Left-edge clamp at the fastest step.
    do_reset("rst2");
    for (int i = 0; i < 52; i++) frame(1, 0, 0, 1, 0, 3, 0);
    check("bnf_s5_max", int'(bus.BossX), 580);
    for (int i = 0; i < 103; i++) frame(1, 0, 0, 1, 0, 3, 0);
    check("bnf_at_65", int'(bus.BossX), 65);
    frame(1, 0, 0, 1, 0, 7, 0);
    check("bnf_clamp_min", int'(bus.BossX), 60);
    frame(1, 0, 0, 1, 0, 7, 0);
    check("bnf_after_flip", int'(bus.BossX), 69);

    // Flydown to the floor, then rise back to the top.
    for (int i = 0; i < 79; i++) frame(1, 1, 0, 0, 0, 0, 0);
    check("down_not_yet", int'(bus.hit_bottom), 0);
    frame(1, 1, 0, 0, 0, 0, 0);
    check("down_floor_y", int'(bus.BossY), 360);
    check("down_hit_bottom", int'(bus.hit_bottom), 1);
    check("down_x_held", int'(bus.BossX), 69);
    for (int i = 0; i < 160; i++) frame(1, 0, 1, 0, 0, 0, 0);
    check("rise_top_y", int'(bus.BossY), 40);
    check("rise_hit_top", int'(bus.hit_top), 1);
    check("rise_x_held", int'(bus.BossX), 69);

    // Continuous bullet hits until defeat.
    do_reset("rst3");
    for (int i = 0; i < 136; i++) frame(1, 0, 0, 0, 1, 0, 1);
    check("hp_zero", int'(bus.boss_hp), 0);
    check("beat_not_yet", int'(bus.beat_Boss), 0);
    frame(1, 0, 0, 0, 1, 0, 1);
    check("beat_set", int'(bus.beat_Boss), 1);
    for (int i = 0; i < 5; i++) frame(1, 0, 0, 0, 1, 0, 1);
    frame(0, 0, 0, 0, 0, 0, 0);
    check("dead_hp_stays", int'(bus.boss_hp), 0);
    check("dead_beat_sticky", int'(bus.beat_Boss), 1);

    // Randomized commands, including multi-hot, against the model.
    do_reset("rst4");
    for (int i = 0; i < 400; i++)
      frame(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
            ($urandom % 2) == 0, ($urandom % 2) == 0, int'($urandom % 8),
            ($urandom % 4) == 0);

    // Park while damaged, then reset mid-flight.
    do_reset("rst5");
    for (int i = 0; i < 46; i++) frame(1, 1, 0, 0, 0, 0, 1);
    check("mid_hp", int'(bus.boss_hp), 10);
    check("mid_y", int'(bus.BossY), 224);
    frame(0, 1, 0, 0, 0, 0, 0);
    check("park_x", int'(bus.BossX), 320);
    check("park_y", int'(bus.BossY), 40);
    check("park_hp", int'(bus.boss_hp), 16);
    for (int i = 0; i < 10; i++) frame(1, 1, 0, 0, 0, 0, 0);
    do_reset("rst_mid");

    repeat (2) @(negedge frame_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
